// File: rtl/cal_edge_search_pkg.sv
// Shared DDR2 calibration definitions: state encoding,
// width helper and default timing shared with the init sequencer.
package cal_edge_search_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETTLE = 3'd1;
  localparam logic [2:0] ST_SAMPLE = 3'd2;
  localparam logic [2:0] ST_DECIDE = 3'd3;
  localparam logic [2:0] ST_ADJUST = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;
  localparam logic [2:0] ST_FAIL   = 3'd6;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    SETTLE = ST_SETTLE,
    SAMPLE = ST_SAMPLE,
    DECIDE = ST_DECIDE,
    ADJUST = ST_ADJUST,
    DONE   = ST_DONE,
    FAIL   = ST_FAIL
  } calState_t;

  localparam int DEF_DIV        = 2;
  localparam int DEF_WIN_LEN    = 64;
  localparam int DEF_SETTLE_CYC = 16;
  localparam int DEF_MAX_TAP    = 63;

  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) begin
    end
    return r;
  endfunction

endpackage

// File: rtl/cal_win_count.sv
// Measurement window: phase divider, sample and ones counters,
// plus a sticky flag showing the reference moved at all.
module cal_win_count
  import cal_edge_search_pkg::*;
#(
  parameter int DIV     = DEF_DIV,
  parameter int WIN_LEN = DEF_WIN_LEN,
  parameter int CNT_W   = clog2(WIN_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             clearAct,
  input  logic             en,
  input  logic             iReg,
  input  logic             dReg,
  output logic [CNT_W-1:0] ones,
  output logic             active,
  output logic             winDone
);

  localparam int PH_W = (DIV > 1) ? clog2(DIV) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(DIV - 1);
  localparam logic [CNT_W-1:0] N_LAST = CNT_W'(WIN_LEN);

  logic [PH_W-1:0]  phase;
  logic [CNT_W-1:0] samples;
  logic [CNT_W-1:0] sampNext;
  logic             take;

  assign take     = en && (phase == '0);
  assign sampNext = samples + CNT_W'(take);
  // Window closes on the last phase slot after the final sample
  assign winDone  = en && (phase == PH_LAST) && (sampNext == N_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      phase   <= '0;
      samples <= '0;
      ones    <= '0;
      active  <= 1'b0;
    end else begin
      if (clear) begin
        phase   <= '0;
        samples <= '0;
        ones    <= '0;
      end else if (en) begin
        phase   <= (phase == PH_LAST) ? '0 : phase + PH_W'(1);
        samples <= sampNext;
        ones    <= ones + CNT_W'(take && dReg);
      end
      if (clearAct) begin
        active <= 1'b0;
      end else if (en && (iReg != dReg)) begin
        active <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cal_edge_search.sv
// Reference-edge search: steps the delay tap until the sampled
// reference is unstable or flips polarity, then reports the tap.
module cal_edge_search
  import cal_edge_search_pkg::*;
#(
  parameter int DIV        = DEF_DIV,
  parameter int WIN_LEN    = DEF_WIN_LEN,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int TAP_W      = 6,
  parameter int MAX_TAP    = DEF_MAX_TAP,
  parameter int CNT_W      = clog2(WIN_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cal_start,
  input  logic             i_reg,
  input  logic             d_reg,
  output logic             tap_inc,
  input  logic             tap_ack,
  output logic [TAP_W-1:0] tap_val,
  output logic             cal_busy,
  output logic             cal_done,
  output logic             cal_fail,
  output logic             edge_pol
);

  localparam int ST_W = clog2(SETTLE_CYC + 1);
  localparam logic [ST_W-1:0] SETTLE_LAST = ST_W'(SETTLE_CYC - 1);
  localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(MAX_TAP);
  localparam logic [CNT_W-1:0] ONES_ALL = CNT_W'(WIN_LEN);

  calState_t        state;
  calState_t        stateNext;
  logic [ST_W-1:0]  settleCnt;
  logic [CNT_W-1:0] ones;
  logic             active;
  logic             winDone;
  logic             startClr;
  logic             polLoad;
  logic             tapStep;
  logic             stable;
  logic             val;

  cal_win_count #(
    .DIV     (DIV),
    .WIN_LEN (WIN_LEN),
    .CNT_W   (CNT_W)
  ) u_win (
    .clk      (clk),
    .reset    (reset),
    .clear    (state == SETTLE),
    .clearAct (startClr),
    .en       (state == SAMPLE),
    .iReg     (i_reg),
    .dReg     (d_reg),
    .ones     (ones),
    .active   (active),
    .winDone  (winDone)
  );

  assign stable = (ones == '0) || (ones == ONES_ALL);
  assign val    = (ones == ONES_ALL);

  always_comb begin
    stateNext = state;
    startClr  = 1'b0;
    polLoad   = 1'b0;
    tapStep   = 1'b0;
    unique case (state)
      IDLE, DONE, FAIL: begin
        if (cal_start) begin
          startClr  = 1'b1;
          stateNext = SETTLE;
        end
      end
      SETTLE: begin
        if (settleCnt == SETTLE_LAST) stateNext = SAMPLE;
      end
      SAMPLE: begin
        if (winDone) stateNext = DECIDE;
      end
      DECIDE: begin
        if (!active) begin
          stateNext = FAIL;
        end else if (!stable) begin
          stateNext = DONE;
        end else if ((tap_val != '0) && (val != edge_pol)) begin
          stateNext = DONE;
        end else begin
          polLoad   = (tap_val == '0);
          stateNext = (tap_val == TAP_LAST) ? FAIL : ADJUST;
        end
      end
      ADJUST: begin
        if (tap_ack) begin
          tapStep   = 1'b1;
          stateNext = SETTLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      settleCnt <= '0;
      tap_val   <= '0;
      edge_pol  <= 1'b0;
    end else begin
      state     <= stateNext;
      settleCnt <= (state == SETTLE) ? settleCnt + ST_W'(1) : '0;
      if (startClr) begin
        tap_val <= '0;
      end else if (tapStep) begin
        tap_val <= tap_val + TAP_W'(1);
      end
      if (polLoad) edge_pol <= val;
    end
  end

  assign tap_inc  = (state == ADJUST);
  assign cal_done = (state == DONE);
  assign cal_fail = (state == FAIL);
  assign cal_busy = !((state == IDLE) || (state == DONE) || (state == FAIL));

endmodule
